// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the skid-buffered pipeline register.
// State encodings double as the occupancy count.
package pipe_skid_stage_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_skid_stage_slot.sv
// Load-enabled data register with asynchronous clear.
// Used for both the main and the skid word of the stage.
module pipe_skid_stage_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // NOTE: payload is reset so out_data reads zero after clr; state updates use <= throughout.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry pipeline register: registered in_ready and out_valid, so a
// downstream stall never forms a combinational ready path upstream.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    state_e            state;
    logic              accept;
    logic              drain;
    logic              main_load;
    logic              skid_load;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        accept    = in_valid & in_ready;
        drain     = out_valid & out_ready;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_data;
        if (!flush) begin
            case (state)
                ST_EMPTY: main_load = accept;
                ST_BUSY: begin
                    main_load = accept & drain;
                    skid_load = accept & ~drain;
                end
                ST_FULL: begin
                    main_load = drain;
                    main_d    = skid_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state     <= ST_BUSY;
                        out_valid <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (accept && !drain) begin
                        state    <= ST_FULL;
                        in_ready <= 1'b0;
                    end else if (!accept && drain) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state    <= ST_BUSY;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign occupancy = state;

    pipe_skid_stage_slot #(.DATA_W(DATA_W)) u_main (
        .clk  (clk),
        .clr  (clr),
        .load (main_load),
        .d    (main_d),
        .q    (out_data)
    );

    pipe_skid_stage_slot #(.DATA_W(DATA_W)) u_skid (
        .clk  (clk),
        .clr  (clr),
        .load (skid_load),
        .d    (in_data),
        .q    (skid_q)
    );

    // Skid-without-main is unencodable; flags must always mirror the state.
    a_state_consistent: assert property (@(posedge clk) disable iff (clr)
        (state != 2'd3) && (in_ready == (state != ST_FULL)) && (out_valid == (state != ST_EMPTY)));

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: accepted words are queued as they are
// driven and compared against the main slot every cycle.
module tb_pipe_skid_stage;

    logic        clk = 1'b0;
    logic        clr;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int          total = 0;
    int          bad = 0;
    logic [31:0] sb[$];
    int          n_out;

    pipe_skid_stage #(.DATA_W(32)) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Check outputs against the model, apply one cycle of stimulus, advance past the edge.
    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
        int          n;
        logic        exp_ready;
        logic        do_acc;
        logic        do_drn;
        logic        stall;
        logic [31:0] held;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        n         = sb.size();
        exp_ready = (n != 2);
        total++;
        if (occupancy !== 2'(n)) begin
            bad++;
            $display("FAIL occupancy: got %0d expected %0d", occupancy, n);
        end
        total++;
        if (in_ready !== exp_ready) begin
            bad++;
            $display("FAIL in_ready: got %b expected %b", in_ready, exp_ready);
        end
        total++;
        if (out_valid !== (n != 0)) begin
            bad++;
            $display("FAIL out_valid: got %b expected %b", out_valid, n != 0);
        end
        if (n != 0) begin
            total++;
            if (out_data !== sb[0]) begin
                bad++;
                $display("FAIL out_data: got %h expected %h", out_data, sb[0]);
            end
        end
        do_acc = v && exp_ready;
        do_drn = r && (n != 0);
        stall  = (n != 0) && !r && !f;
        held   = out_data;
        if (f) begin
            sb.delete();
        end else begin
            if (do_drn) begin
                void'(sb.pop_front());
                n_out++;
            end
            if (do_acc) sb.push_back(d);
        end
        @(posedge clk);
        #1;
        if (stall) begin
            total++;
            if (out_data !== held || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold: got %h/%b expected %h/1", out_data, out_valid, held);
            end
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_init: got v=%b r=%b occ=%0d d=%h expected 0/1/0/0",
                     out_valid, in_ready, occupancy, out_data);
        end
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        // Get into BUSY, then clear between clock edges.
        step(1'b1, 32'hC0DE_0001, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        clr = 1'b1;
        #2;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_async: got v=%b r=%b occ=%0d d=%h expected 0/1/0/0",
                     out_valid, in_ready, occupancy, out_data);
        end
        #1;
        clr = 1'b0;
        sb.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        n_out = 0;
        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        total++;
        if (n_out !== 8) begin
            bad++;
            $display("FAIL stream_count: got %0d expected 8", n_out);
        end
    endtask

    task automatic test_fill_drain();
        step(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
        step(1'b1, 32'hAAAA_0002, 1'b0, 1'b0);
        total++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hAAAA_0001) begin
            bad++;
            $display("FAIL fill: got occ=%0d r=%b d=%h expected 2/0/aaaa0001",
                     occupancy, in_ready, out_data);
        end
        step(1'b1, 32'hDEAD_DEAD, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_full_refill();
        n_out = 0;
        step(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
        step(1'b1, 32'hAAAA_0002, 1'b0, 1'b0);
        step(1'b1, 32'h0000_BEEF, 1'b1, 1'b0);
        total++;
        if (in_ready !== 1'b1 || out_data !== 32'hAAAA_0002) begin
            bad++;
            $display("FAIL refill: got r=%b d=%h expected 1/aaaa0002", in_ready, out_data);
        end
        step(1'b1, 32'h0000_BEEF, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        total++;
        if (n_out !== 3) begin
            bad++;
            $display("FAIL refill_count: got %0d expected 3", n_out);
        end
    endtask

    task automatic test_flush();
        step(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
        step(1'b1, 32'hAAAA_0002, 1'b0, 1'b0);
        step(1'b1, 32'h0000_1234, 1'b1, 1'b1);
        total++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush: got v=%b occ=%0d r=%b expected 0/0/1", out_valid, occupancy, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            total++;
            if (out_valid && out_data === 32'h0000_1234) begin
                bad++;
                $display("FAIL flush_drop: got %h expected not 00001234", out_data);
            end
        end
        step(1'b1, 32'h5555_0001, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 99) < 60), $urandom(),
                 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        total++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL random_drain: got left=%0d v=%b expected 0/0", sb.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_drain();
        test_full_refill();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
